// File: rtl/tetris_input_pkg.sv
// Shared types for the Tetris input path: action ids, scheduler states
// and a width helper used by the scheduler and its picker.
package tetris_input_pkg;

    typedef enum logic [2:0] {
        MOVE_LEFT  = 3'd0,
        MOVE_RIGHT = 3'd1,
        ROTATE_CW  = 3'd2,
        SOFT_DROP  = 3'd3,
        HARD_DROP  = 3'd4
    } action_t;

    localparam int NUM_ACTIONS_DEF = 5;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLDOFF
    } sched_state_t;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/input_action_scheduler_if.sv
// DAS-side pulses/enables and engine-side command handshake.
// master = scheduler, slave = DAS channels plus game engine.
interface input_action_scheduler_if
    import tetris_input_pkg::*;
#(
    parameter int NUM_ACTIONS = NUM_ACTIONS_DEF
);
    localparam int IW = clog2_min1(NUM_ACTIONS);

    logic [NUM_ACTIONS-1:0] action_pulse;
    logic [NUM_ACTIONS-1:0] action_valid;
    logic                   game_active;
    logic                   cmd_valid;
    logic [IW-1:0]          cmd_id;
    logic                   cmd_ready;
    logic                   holdoff_busy;

    modport master (
        input  action_pulse,
        output action_valid,
        input  game_active,
        output cmd_valid,
        output cmd_id,
        input  cmd_ready,
        output holdoff_busy
    );

    modport slave (
        output action_pulse,
        input  action_valid,
        output game_active,
        input  cmd_valid,
        input  cmd_id,
        output cmd_ready,
        input  holdoff_busy
    );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational picker: priority index wins if pending, otherwise the
// first pending index at or after rr_ptr, wrapping modulo NUM_ACTIONS.
module rr_priority_picker
    import tetris_input_pkg::*;
#(
    parameter int NUM_ACTIONS = NUM_ACTIONS_DEF,
    parameter int IW          = clog2_min1(NUM_ACTIONS)
) (
    input  logic [NUM_ACTIONS-1:0] pending,
    input  logic [IW-1:0]          rr_ptr,
    input  logic [IW-1:0]          prio_idx,
    output logic [IW-1:0]          winner,
    output logic                   any_pending
);
    localparam logic [IW:0] N_EXT = (IW+1)'(NUM_ACTIONS);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NUM_ACTIONS; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= N_EXT) begin
                sum = sum - N_EXT;
            end
            idx = sum[IW-1:0];
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
        if (pending[prio_idx]) begin
            winner = prio_idx;
        end
        any_pending = |pending;
    end
endmodule

// File: rtl/input_action_scheduler.sv
// Queues DAS action pulses, arbitrates them (hard drop first, others
// round-robin) and issues one command at a time to the game engine.
module input_action_scheduler
    import tetris_input_pkg::*;
#(
    parameter int NUM_ACTIONS    = NUM_ACTIONS_DEF,
    parameter int HARD_DROP_IDX  = int'(HARD_DROP),
    parameter int HOLDOFF_CYCLES = 50_000
) (
    input logic                      clk,
    input logic                      rst,
    input_action_scheduler_if.master bus
);
    localparam int IW = clog2_min1(NUM_ACTIONS);
    localparam int CW = clog2_min1(HOLDOFF_CYCLES);

    localparam logic [IW-1:0] HD_ID    = IW'(HARD_DROP_IDX);
    localparam logic [IW-1:0] LAST_ID  = IW'(NUM_ACTIONS - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLDOFF_CYCLES - 1);

    sched_state_t           state, state_n;
    logic [NUM_ACTIONS-1:0] pending, pending_n;
    logic [IW-1:0]          rr_ptr, rr_ptr_n;
    logic [IW-1:0]          cmd_id, cmd_id_n;
    logic [CW-1:0]          count, count_n;

    logic [NUM_ACTIONS-1:0] enable;
    logic [NUM_ACTIONS-1:0] capture;
    logic [IW-1:0]          winner;
    logic                   any_pending;

    rr_priority_picker #(
        .NUM_ACTIONS (NUM_ACTIONS),
        .IW          (IW)
    ) u_picker (
        .pending     (pending),
        .rr_ptr      (rr_ptr),
        .prio_idx    (HD_ID),
        .winner      (winner),
        .any_pending (any_pending)
    );

    // Channels already pending are masked so pulses drop, never stack.
    always_comb begin
        enable = '0;
        if (!rst && bus.game_active && state != HOLDOFF) begin
            enable = ~pending;
        end
        capture = bus.action_pulse & enable;
    end

    assign bus.action_valid = enable;
    assign bus.cmd_valid    = (state == ISSUE);
    assign bus.cmd_id       = cmd_id;
    assign bus.holdoff_busy = (state == HOLDOFF);

    always_comb begin
        state_n   = state;
        pending_n = pending | capture;
        rr_ptr_n  = rr_ptr;
        cmd_id_n  = cmd_id;
        count_n   = count;
        unique case (state)
            IDLE: begin
                if (!bus.game_active) begin
                    pending_n = '0;
                end else if (any_pending) begin
                    cmd_id_n = winner;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.cmd_ready) begin
                    pending_n[cmd_id] = 1'b0;
                    if (cmd_id == HD_ID) begin
                        pending_n = '0;
                        count_n   = CNT_LOAD;
                        state_n   = HOLDOFF;
                    end else begin
                        rr_ptr_n = (cmd_id == LAST_ID) ? '0 : cmd_id + 1'b1;
                        if (!bus.game_active) begin
                            pending_n = '0;
                        end
                        state_n = IDLE;
                    end
                end
            end
            HOLDOFF: begin
                pending_n = '0;
                if (count == '0) begin
                    state_n = IDLE;
                end else begin
                    count_n = count - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            rr_ptr  <= '0;
            cmd_id  <= '0;
            count   <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            rr_ptr  <= rr_ptr_n;
            cmd_id  <= cmd_id_n;
            count   <= count_n;
        end
    end
endmodule

// File: tb/tb_input_action_scheduler.sv
// Directed bench: stimulus pushes expected command ids into a queue,
// a negedge monitor pops and compares on every accepted command.
module tb_input_action_scheduler;
    import tetris_input_pkg::*;

    localparam int N  = 5;
    localparam int HO = 8;

    logic clk;
    logic rst;

    input_action_scheduler_if #(.NUM_ACTIONS(N)) bus ();

    input_action_scheduler #(
        .NUM_ACTIONS    (N),
        .HARD_DROP_IDX  (4),
        .HOLDOFF_CYCLES (HO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total  = 0;
    int passed = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.cmd_valid && bus.cmd_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_cmd: got id %0d expected none",
                         bus.cmd_id);
            end else begin
                check("cmd_order", int'(bus.cmd_id), exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        bus.action_pulse = m;
        tick(1);
        bus.action_pulse = '0;
    endtask

    task automatic wait_busy(input string name);
        int i;
        for (i = 0; i < 10 && !bus.holdoff_busy; i++) begin
            @(negedge clk);
        end
        check(name, int'(bus.holdoff_busy), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hc;
        bit seen;
        clk              = 1'b0;
        rst              = 1'b1;
        bus.action_pulse = '0;
        bus.game_active  = 1'b1;
        bus.cmd_ready    = 1'b1;

        // reset
        @(negedge clk);
        check("av_in_rst", int'(bus.action_valid), 0);
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_valid", int'(bus.cmd_valid), 0);
        check("rst_cmd_id", int'(bus.cmd_id), 0);
        check("rst_busy", int'(bus.holdoff_busy), 0);
        check("rst_av", int'(bus.action_valid), 'h1f);
        tick(1);

        // single action, latency and masking
        exp_q.push_back(1);
        pulse(5'b00010);
        @(negedge clk);
        check("t1_av_pend", int'(bus.action_valid), 'h1d);
        check("t1_valid_early", int'(bus.cmd_valid), 0);
        @(negedge clk);
        check("t1_valid", int'(bus.cmd_valid), 1);
        check("t1_id", int'(bus.cmd_id), 1);
        check("t1_av_issue", int'(bus.action_valid), 'h1d);
        @(negedge clk);
        check("t1_idle", int'(bus.cmd_valid), 0);
        check("t1_av_free", int'(bus.action_valid), 'h1f);
        tick(2);

        // round robin from rr_ptr=2: 3, 0, 1 then 3 before 1
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(1);
        pulse(5'b01011);
        tick(10);
        exp_q.push_back(3);
        exp_q.push_back(1);
        pulse(5'b01010);
        tick(8);

        // backpressure
        bus.cmd_ready = 1'b0;
        exp_q.push_back(2);
        pulse(5'b00100);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) bus.action_pulse = 5'b00001;
            @(negedge clk);
            check("bp_valid", int'(bus.cmd_valid), 1);
            check("bp_id", int'(bus.cmd_id), 2);
            tick(1);
            bus.action_pulse = '0;
        end
        exp_q.push_back(0);
        bus.cmd_ready = 1'b1;
        tick(6);

        // hard drop priority and holdoff
        exp_q.push_back(4);
        pulse(5'b10101);
        hc   = 0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.holdoff_busy) begin
                seen = 1'b1;
                hc++;
                check("ho_av", int'(bus.action_valid), 0);
                bus.action_pulse = (hc == 3) ? 5'b00011 : '0;
            end else if (seen) begin
                break;
            end
        end
        bus.action_pulse = '0;
        check("ho_len", hc, HO);
        tick(4);
        check("ho_after_valid", int'(bus.cmd_valid), 0);
        check("ho_after_av", int'(bus.action_valid), 'h1f);

        // game_active drop in IDLE
        pulse(5'b01010);
        bus.game_active = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ga_idle_valid", int'(bus.cmd_valid), 0);
            check("ga_idle_av", int'(bus.action_valid), 0);
        end
        tick(1);
        bus.game_active = 1'b1;
        @(negedge clk);
        check("ga_idle_clr", int'(bus.action_valid), 'h1f);
        tick(3);
        check("ga_idle_none", int'(bus.cmd_valid), 0);

        // game_active drop during ISSUE
        bus.cmd_ready = 1'b0;
        exp_q.push_back(1);
        pulse(5'b01010);
        tick(1);
        bus.game_active = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ga_iss_valid", int'(bus.cmd_valid), 1);
            check("ga_iss_id", int'(bus.cmd_id), 1);
        end
        tick(1);
        bus.cmd_ready = 1'b1;
        tick(1);
        bus.game_active = 1'b1;
        tick(4);
        check("ga_iss_none", int'(bus.cmd_valid), 0);
        check("ga_iss_av", int'(bus.action_valid), 'h1f);

        // reset during holdoff
        exp_q.push_back(4);
        pulse(5'b10000);
        wait_busy("mr_busy_seen");
        tick(2);
        rst = 1'b1;
        @(negedge clk);
        check("mr_av_rst", int'(bus.action_valid), 0);
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("mr_busy", int'(bus.holdoff_busy), 0);
        check("mr_valid", int'(bus.cmd_valid), 0);
        check("mr_id", int'(bus.cmd_id), 0);
        check("mr_av", int'(bus.action_valid), 'h1f);
        tick(1);
        exp_q.push_back(1);
        exp_q.push_back(2);
        pulse(5'b00110);
        tick(8);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
